lfo_delay_gen: RTL and testbench

- Triangle-wave LFO; produces the signed per-sample delay offset and its valid strobe consumed by the SPRAM delay buffer (extraDelay / LFOChanged inputs) for chorus/flanger.
- Advances once per audio sample strobe. Computes a fresh offset with a sequential shift-add multiply. Strobes the result a fixed latency later.
- Strobes exactly once per accepted sample so the buffer's WAIT state never stalls.

---
 rtl/lfo_pkg.sv | 27 ++
 rtl/lfo_delay_gen_if.sv | 24 ++
 rtl/seq_mul_su.sv | 53 +++++
 rtl/lfo_delay_gen.sv | 111 +++++++++++
 tb/tb_lfo_delay_gen.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/lfo_pkg.sv
// Shared constants, state encoding and the phase-to-triangle mapping for the LFO.
package lfo_pkg;

  localparam int unsigned LFO_PHASE_WIDTH = 24;
  localparam int unsigned LFO_ADDR_WIDTH  = 14;
  localparam int unsigned LFO_DEPTH_WIDTH = 8;
  localparam int unsigned LFO_SCALE_SHIFT = 13;
  localparam int unsigned TRI_WIDTH       = 16;

  typedef enum logic [2:0] {
    LFO_RESET = 3'd0,
    LFO_IDLE  = 3'd1,
    LFO_ACCUM = 3'd2,
    LFO_SHAPE = 3'd3,
    LFO_MUL   = 3'd4,
    LFO_DONE  = 3'd5,
    LFO_ERROR = 3'd6
  } lfo_state_t;

  // Fold the top phase bits into a symmetric signed triangle; continuous across wrap.
  function automatic logic signed [TRI_WIDTH-1:0] phase_to_tri(input logic [TRI_WIDTH-1:0] u);
    logic [TRI_WIDTH-1:0] tri_u;
    tri_u = u[TRI_WIDTH-1] ? ~{u[TRI_WIDTH-2:0], 1'b0} : {u[TRI_WIDTH-2:0], 1'b0};
    return $signed({~tri_u[TRI_WIDTH-1], tri_u[TRI_WIDTH-2:0]});
  endfunction

endpackage

// File: rtl/lfo_delay_gen_if.sv
// Sample-strobe / control / offset bundle between the audio datapath and the LFO.
interface lfo_delay_gen_if #(
  parameter int unsigned PHASE_WIDTH = lfo_pkg::LFO_PHASE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = lfo_pkg::LFO_ADDR_WIDTH,
  parameter int unsigned DEPTH_WIDTH = lfo_pkg::LFO_DEPTH_WIDTH
);
  logic                          pktChanged_s_i;
  logic                          enable_s_i;
  logic [PHASE_WIDTH-1:0]        rate_s_i;
  logic [DEPTH_WIDTH-1:0]        depth_s_i;
  logic signed [ADDR_WIDTH-1:0]  extraDelay_s_o;
  logic                          LFOChanged_c_o;
  logic                          errorLED_s_o;

  modport master (
    output pktChanged_s_i, enable_s_i, rate_s_i, depth_s_i,
    input  extraDelay_s_o, LFOChanged_c_o, errorLED_s_o
  );

  modport slave (
    input  pktChanged_s_i, enable_s_i, rate_s_i, depth_s_i,
    output extraDelay_s_o, LFOChanged_c_o, errorLED_s_o
  );
endinterface

// File: rtl/seq_mul_su.sv
// Signed x unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module seq_mul_su #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic        [B_WIDTH-1:0]         b,
  output logic                              busy,
  output logic                              done_c,
  output logic signed [A_WIDTH+B_WIDTH-1:0] product_c
);
  localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned CNT_WIDTH = $clog2(B_WIDTH + 1);

  logic        [CNT_WIDTH-1:0] cnt;
  logic signed [P_WIDTH-1:0]   a_sh;
  logic        [B_WIDTH-1:0]   b_sh;
  logic signed [P_WIDTH-1:0]   acc;
  logic signed [P_WIDTH-1:0]   addend_c;

  // Partial product for the current bit; product_c is the running sum after this cycle.
  always_comb begin
    addend_c  = b_sh[0] ? a_sh : '0;
    product_c = acc + addend_c;
    done_c    = busy && (cnt == '0);
  end

  // Operand shift registers, accumulator and down-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_WIDTH'(B_WIDTH - 1);
      a_sh <= P_WIDTH'(a);
      b_sh <= b;
      acc  <= '0;
    end else if (busy) begin
      acc  <= product_c;
      a_sh <= a_sh <<< 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - CNT_WIDTH'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/lfo_delay_gen.sv
// Triangle LFO producing one signed delay offset and one strobe per accepted sample.
module lfo_delay_gen
  import lfo_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = LFO_PHASE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = LFO_ADDR_WIDTH,
  parameter int unsigned DEPTH_WIDTH = LFO_DEPTH_WIDTH,
  parameter int unsigned SCALE_SHIFT = LFO_SCALE_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  lfo_delay_gen_if.slave bus
);
  localparam int unsigned PROD_WIDTH = TRI_WIDTH + DEPTH_WIDTH;

  localparam logic [2:0] S_RESET = 3'(LFO_RESET);
  localparam logic [2:0] S_IDLE  = 3'(LFO_IDLE);
  localparam logic [2:0] S_ACCUM = 3'(LFO_ACCUM);
  localparam logic [2:0] S_SHAPE = 3'(LFO_SHAPE);
  localparam logic [2:0] S_MUL   = 3'(LFO_MUL);
  localparam logic [2:0] S_DONE  = 3'(LFO_DONE);
  localparam logic [2:0] S_ERROR = 3'(LFO_ERROR);

  logic [2:0]                    state, state_d;
  logic [PHASE_WIDTH-1:0]        phase, phase_d;
  logic signed [ADDR_WIDTH-1:0]  delay, delay_d;
  logic                          err, err_d;

  logic signed [TRI_WIDTH-1:0]   tri_s_c;
  logic [DEPTH_WIDTH-1:0]        depth_c;
  logic                          mul_start_c;
  logic                          mul_busy;
  logic                          mul_done_c;
  logic signed [PROD_WIDTH-1:0]  product_c;
  logic signed [PROD_WIDTH-1:0]  scaled_c;

  // Multiplier operands; both are only captured by the multiplier during SHAPE.
  always_comb begin
    tri_s_c     = phase_to_tri(phase[PHASE_WIDTH-1 -: TRI_WIDTH]);
    depth_c     = bus.enable_s_i ? bus.depth_s_i : '0;
    mul_start_c = (state == S_SHAPE);
    scaled_c    = product_c >>> SCALE_SHIFT;
  end

  seq_mul_su #(
    .A_WIDTH (TRI_WIDTH),
    .B_WIDTH (DEPTH_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .a         (tri_s_c),
    .b         (depth_c),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (product_c)
  );

  // Next-state, phase, offset and sticky-error logic.
  always_comb begin
    state_d = state;
    phase_d = phase;
    delay_d = delay;
    err_d   = err;
    case (state)
      S_RESET: state_d = S_IDLE;
      S_IDLE:  if (bus.pktChanged_s_i) state_d = S_ACCUM;
      S_ACCUM: begin
        phase_d = bus.enable_s_i ? phase + bus.rate_s_i : '0;
        state_d = S_SHAPE;
      end
      S_SHAPE: state_d = S_MUL;
      S_MUL: begin
        if (!mul_busy) begin
          state_d = S_ERROR;
        end else if (mul_done_c) begin
          delay_d = ADDR_WIDTH'(scaled_c);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = bus.pktChanged_s_i ? S_ACCUM : S_IDLE;
      S_ERROR: begin
        err_d   = 1'b1;
        state_d = S_RESET;
      end
      default: state_d = S_ERROR;
    endcase
    // A sample arriving mid-computation is dropped and flagged.
    if (bus.pktChanged_s_i && (state == S_ACCUM || state == S_SHAPE || state == S_MUL))
      err_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RESET;
      phase <= '0;
      delay <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      delay <= delay_d;
      err   <= err_d;
    end
  end

  assign bus.extraDelay_s_o = delay;
  assign bus.LFOChanged_c_o = (state == S_DONE);
  assign bus.errorLED_s_o   = err;
endmodule

// File: tb/tb_lfo_delay_gen.sv
// Directed scoreboard bench for lfo_delay_gen: offset values, strobe latency and error flag.
module tb_lfo_delay_gen;

  localparam int LATENCY = lfo_pkg::LFO_DEPTH_WIDTH + 3;

  typedef struct {
    logic signed [31:0] value;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   sweep_exp[4];

  always #5 clk = ~clk;

  lfo_delay_gen_if bus_if ();

  lfo_delay_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Advance one cycle and score any strobe against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    int   pending;
    @(negedge clk);
    cyc++;
    if (bus_if.LFOChanged_c_o === 1'b1) begin
      pending = sb.size();
      chk("strobe_expected", 32'(pending != 0), 32'sd1);
      if (pending != 0) begin
        e = sb.pop_front();
        chk("offset_value", 32'(bus_if.extraDelay_s_o), e.value);
        chk("strobe_latency", cyc, e.cyc);
      end
    end
  endtask

  task automatic send(input logic [23:0] rate, input logic [7:0] depth, input logic en, input int expv);
    exp_t e;
    bus_if.rate_s_i       = rate;
    bus_if.depth_s_i      = depth;
    bus_if.enable_s_i     = en;
    bus_if.pktChanged_s_i = 1'b1;
    e.value = expv;
    e.cyc   = cyc + LATENCY;
    sb.push_back(e);
    tick();
    bus_if.pktChanged_s_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_timeout", sb.size(), 32'sd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    bus_if.pktChanged_s_i = 1'b0;
    bus_if.enable_s_i     = 1'b0;
    bus_if.rate_s_i       = '0;
    bus_if.depth_s_i      = '0;
    sweep_exp = '{0, 1019, -1, -1020};

    // Reset state
    repeat (3) tick();
    chk("rst_offset", 32'(bus_if.extraDelay_s_o), 32'sd0);
    chk("rst_strobe", 32'(bus_if.LFOChanged_c_o), 32'sd0);
    chk("rst_error", 32'(bus_if.errorLED_s_o), 32'sd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Quarter-cycle sweep
    for (int i = 0; i < 4; i++) begin
      send(24'h400000, 8'd255, 1'b1, sweep_exp[i]);
      drain();
    end

    // Reset in the middle of MUL aborts the sample
    send(24'h400000, 8'd255, 1'b1, 0);
    repeat (4) tick();
    do_reset();
    chk("midmul_rst_offset", 32'(bus_if.extraDelay_s_o), 32'sd0);
    chk("midmul_rst_strobe", 32'(bus_if.LFOChanged_c_o), 32'sd0);
    chk("midmul_rst_error", 32'(bus_if.errorLED_s_o), 32'sd0);
    repeat (20) tick();

    // Depth scaling
    send(24'h800000, 8'd128, 1'b1, 511);
    drain();
    send(24'h800000, 8'd0, 1'b1, 0);
    drain();

    // Enable low forces zero, phase restarts from rate on re-enable
    for (int i = 0; i < 3; i++) begin
      send(24'h123456, 8'd255, 1'b0, 0);
      drain();
    end
    send(24'h123456, 8'd255, 1'b1, -730);
    drain();

    // Overrun: second strobe 4 cycles later is dropped and latched as error
    do_reset();
    send(24'h800000, 8'd255, 1'b1, 1019);
    repeat (3) tick();
    bus_if.pktChanged_s_i = 1'b1;
    tick();
    bus_if.pktChanged_s_i = 1'b0;
    drain();
    chk("overrun_error", 32'(bus_if.errorLED_s_o), 32'sd1);
    send(24'h800000, 8'd255, 1'b1, -1020);
    drain();
    chk("overrun_error_sticky", 32'(bus_if.errorLED_s_o), 32'sd1);
    do_reset();
    chk("error_cleared", 32'(bus_if.errorLED_s_o), 32'sd0);

    // Back-to-back: sample accepted during DONE
    send(24'h400000, 8'd255, 1'b1, 0);
    repeat (LATENCY - 1) tick();
    send(24'h400000, 8'd255, 1'b1, 1019);
    drain();
    chk("b2b_error", 32'(bus_if.errorLED_s_o), 32'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
